// File: rtl/sam_con_feeder.sv
// sam_con_feeder: buffers data words in a small FIFO and streams them to the SAM
//   convolver, serialising the ternary kernel on the 2-bit lane during priming.
// Latency: a pushed word reaches Data_Out one edge after its push at the earliest;
//   all stream outputs are registered.
// Backpressure: Push_Ready drops when the FIFO is full; an empty FIFO stalls the
//   stream (En=0) for as long as needed.
// Ports:
//   Clk, Rst_n            clock, async active-low reset
//   Start, Abort          job start pulse (IDLE only) / synchronous flush
//   KERNEL_SIZE, Num_Words, Kernel_Word   job config, sampled on Start
//   Push_Valid/Data/Ready word push interface
//   En, Data_Out, Kernel_Serial_Output, Last_Data_Out   convolver stream
//   Busy, Done, Error     status
module sam_con_feeder #(
  parameter int MAX_KERNEL_SIZE = 16,
  parameter int FIFO_DEPTH      = 8,
  parameter int DATA_W          = 32
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic                         Start,
  input  logic                         Abort,
  input  logic [7:0]                   KERNEL_SIZE,
  input  logic [15:0]                  Num_Words,
  input  logic [2*MAX_KERNEL_SIZE-1:0] Kernel_Word,
  input  logic                         Push_Valid,
  input  logic [DATA_W-1:0]            Push_Data,
  output logic                         Push_Ready,
  output logic                         En,
  output logic [DATA_W-1:0]            Data_Out,
  output logic [1:0]                   Kernel_Serial_Output,
  output logic                         Last_Data_Out,
  output logic                         Busy,
  output logic                         Done,
  output logic                         Error
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  // ---------------- FIFO storage ----------------
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_full, w_empty, w_push, w_pop;
  logic [DATA_W-1:0] w_head;

  // ---------------- job config / counters ----------------
  logic [7:0]                   r_ksize;
  logic [15:0]                  r_nwords;
  logic [2*MAX_KERNEL_SIZE-1:0] r_kword;
  logic [7:0]                   r_elem_idx, w_elem_nxt;
  logic [15:0]                  r_word_cnt, w_wcnt_nxt;
  logic                         w_cfg_load, w_cfg_bad;

  // ---------------- registered outputs ----------------
  logic              r_en, w_en_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic [1:0]        r_kso, w_kso_nxt;
  logic              r_last, w_last_nxt;
  logic              r_done, w_done_nxt;
  logic              r_error, w_error_nxt;

  logic [2*MAX_KERNEL_SIZE-1:0] w_kshift;
  logic [1:0]                   w_kelem;

  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_head     = r_mem[r_rd_ptr];
  assign Push_Ready = !w_full;
  // A full FIFO refuses the push even if a pop frees a slot on the same edge.
  assign w_push     = Push_Valid && !w_full;

  // Element elem_idx sits at bits [2i+1:2i].
  assign w_kshift = r_kword >> {r_elem_idx, 1'b0};
  assign w_kelem  = w_kshift[1:0];

  assign w_cfg_bad = (KERNEL_SIZE == 8'd0) ||
                     (int'(KERNEL_SIZE) > MAX_KERNEL_SIZE) ||
                     (Num_Words <= {8'd0, KERNEL_SIZE});

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state and datapath ----------------
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_en_nxt    = 1'b0;
    w_data_nxt  = r_data;
    w_kso_nxt   = 2'b00;
    w_last_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_error_nxt = r_error;
    w_elem_nxt  = r_elem_idx;
    w_wcnt_nxt  = r_word_cnt;
    w_cfg_load  = 1'b0;

    if (Abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (Start) begin
            if (w_cfg_bad) begin
              w_error_nxt = 1'b1;
            end else begin
              w_error_nxt = 1'b0;
              w_elem_nxt  = '0;
              w_wcnt_nxt  = '0;
              w_cfg_load  = 1'b1;
              w_state_nxt = S_PRIME;
            end
          end
        end
        S_PRIME: begin
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_en_nxt   = 1'b1;
            w_data_nxt = w_head;
            w_kso_nxt  = w_kelem;
            w_elem_nxt = r_elem_idx + 8'd1;
            w_wcnt_nxt = r_word_cnt + 16'd1;
            if (r_elem_idx == r_ksize - 8'd1) w_state_nxt = S_STREAM;
          end
        end
        S_STREAM: begin
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_en_nxt   = 1'b1;
            w_data_nxt = w_head;
            w_wcnt_nxt = r_word_cnt + 16'd1;
            // Config validation guarantees Num_Words > KERNEL_SIZE, so the last
            // word always falls in STREAM.
            if (r_word_cnt == r_nwords - 16'd1) begin
              w_last_nxt  = 1'b1;
              w_state_nxt = S_DONE;
            end
          end
        end
        S_DONE: begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------- FIFO pointers / count ----------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (Abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (w_push && !Abort) r_mem[r_wr_ptr] <= Push_Data;
  end

  // ---------------- config, counters, outputs ----------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ksize    <= '0;
      r_nwords   <= '0;
      r_kword    <= '0;
      r_elem_idx <= '0;
      r_word_cnt <= '0;
      r_en       <= 1'b0;
      r_data     <= '0;
      r_kso      <= 2'b00;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      if (w_cfg_load) begin
        r_ksize  <= KERNEL_SIZE;
        r_nwords <= Num_Words;
        r_kword  <= Kernel_Word;
      end
      r_elem_idx <= w_elem_nxt;
      r_word_cnt <= w_wcnt_nxt;
      r_en       <= w_en_nxt;
      r_data     <= w_data_nxt;
      r_kso      <= w_kso_nxt;
      r_last     <= w_last_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
    end
  end

  assign En                   = r_en;
  assign Data_Out             = r_data;
  assign Kernel_Serial_Output = r_kso;
  assign Last_Data_Out        = r_last;
  assign Done                 = r_done;
  assign Error                = r_error;
  assign Busy                 = (r_state == S_PRIME) || (r_state == S_STREAM);

endmodule

// File: tb/tb_sam_con_feeder.sv
// Bench for sam_con_feeder: directed scenarios followed by random traffic, all
// checked cycle by cycle against a queue-based job model.
module tb_sam_con_feeder;

  localparam int DEPTH = 8;
  localparam int MAXK  = 16;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic [7:0]  KERNEL_SIZE = '0;
  logic [15:0] Num_Words = '0;
  logic [31:0] Kernel_Word = '0;
  logic        Push_Valid = 1'b0;
  logic [31:0] Push_Data = '0;
  logic        Push_Ready;
  logic        En;
  logic [31:0] Data_Out;
  logic [1:0]  Kernel_Serial_Output;
  logic        Last_Data_Out;
  logic        Busy;
  logic        Done;
  logic        Error;

  sam_con_feeder #(.MAX_KERNEL_SIZE(MAXK), .FIFO_DEPTH(DEPTH), .DATA_W(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Abort(Abort),
    .KERNEL_SIZE(KERNEL_SIZE), .Num_Words(Num_Words), .Kernel_Word(Kernel_Word),
    .Push_Valid(Push_Valid), .Push_Data(Push_Data), .Push_Ready(Push_Ready),
    .En(En), .Data_Out(Data_Out), .Kernel_Serial_Output(Kernel_Serial_Output),
    .Last_Data_Out(Last_Data_Out), .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [31:0] q[$];        // words waiting in the FIFO
  bit          m_job;       // a job is streaming (priming or data phase)
  bit          m_donep;     // last word sent, completion pulse still owed
  bit          m_err;
  int          m_k, m_n, m_sent;
  logic [31:0] m_kw;
  logic [31:0] e_data;
  bit          e_en, e_last, e_done;
  logic [1:0]  e_kel;
  int          n_strobes;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_job = 0; m_donep = 0; m_err = 0;
    m_k = 0; m_n = 0; m_sent = 0; m_kw = '0;
    e_data = '0; e_en = 0; e_last = 0; e_done = 0; e_kel = 2'b00;
  endtask

  // One clock: predict the effect of the current inputs, clock, then compare.
  task automatic cycle();
    bit do_push;
    do_push = Push_Valid && (q.size() < DEPTH);
    e_en = 0; e_last = 0; e_kel = 2'b00; e_done = 0;
    if (Abort) begin
      q.delete();
      m_job = 0;
      m_donep = 0;
    end else begin
      if (m_donep) begin
        e_done = 1;
        m_donep = 0;
      end else if (m_job) begin
        if (q.size() != 0) begin
          e_data = q.pop_front();
          e_en = 1;
          if (m_sent < m_k) e_kel = 2'(m_kw >> (2 * m_sent));
          if (m_sent == m_n - 1) begin
            e_last = 1;
            m_job = 0;
            m_donep = 1;
          end
          m_sent++;
        end
      end else if (Start) begin
        if (KERNEL_SIZE == 0 || int'(KERNEL_SIZE) > MAXK || Num_Words <= {8'd0, KERNEL_SIZE}) begin
          m_err = 1;
        end else begin
          m_err = 0;
          m_job = 1;
          m_sent = 0;
          m_k = int'(KERNEL_SIZE);
          m_n = int'(Num_Words);
          m_kw = Kernel_Word;
        end
      end
      if (do_push) q.push_back(Push_Data);
    end
    @(posedge Clk);
    #1;
    chk("en", En, e_en);
    chk("data", Data_Out, e_data);
    chk("kernel", Kernel_Serial_Output, e_kel);
    chk("last", Last_Data_Out, e_last);
    chk("done", Done, e_done);
    chk("busy", Busy, m_job);
    chk("error", Error, m_err);
    chk("push_ready", Push_Ready, q.size() < DEPTH);
    if (e_en) n_strobes++;
  endtask

  task automatic drv(input bit pv, input logic [31:0] d, input bit st, input bit ab);
    Push_Valid = pv;
    Push_Data  = d;
    Start      = st;
    Abort      = ab;
    cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_en"}, En, 1'b0);
    chk({tag, "_data"}, Data_Out, 32'h0);
    chk({tag, "_kernel"}, Kernel_Serial_Output, 2'b00);
    chk({tag, "_last"}, Last_Data_Out, 1'b0);
    chk({tag, "_busy"}, Busy, 1'b0);
    chk({tag, "_done"}, Done, 1'b0);
    chk({tag, "_error"}, Error, 1'b0);
  endtask

  task automatic set_cfg(input logic [7:0] k, input logic [15:0] n, input logic [31:0] kw);
    KERNEL_SIZE = k;
    Num_Words   = n;
    Kernel_Word = kw;
  endtask

  initial begin
    int base, guard;
    bit acc;
    n_strobes = 0;
    model_clear();

    // Power-on reset
    #12;
    check_reset_outputs("rst");
    Rst_n = 1'b1;
    #1;
    chk("rst_push_ready", Push_Ready, 1'b1);

    // Preloaded job: kernel {+1,-1,0}, six words
    for (int i = 0; i < 6; i++) drv(1, 32'h10 + i, 0, 0);
    set_cfg(8'd3, 16'd6, 32'h0000_000D);
    drv(0, 0, 1, 0);
    repeat (10) drv(0, 0, 0, 0);

    // Same job, starved FIFO: one word every third cycle
    drv(0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      drv(1, 32'h10 + i, 0, 0);
      drv(0, 0, 0, 0);
      drv(0, 0, 0, 0);
    end
    repeat (5) drv(0, 0, 0, 0);

    // Fill past capacity; the ninth word waits until a pop frees a slot
    for (int i = 0; i < 9; i++) drv(1, 32'h20 + i, 0, 0);
    set_cfg(8'd2, 16'd9, 32'h0000_0007);
    drv(1, 32'h28, 1, 0);
    acc = 0;
    guard = 0;
    while (!acc && guard < 20) begin
      acc = (q.size() < DEPTH);
      drv(1, 32'h28, 0, 0);
      guard++;
    end
    chk("ninth_word_accepted", acc, 1'b1);
    repeat (12) drv(0, 0, 0, 0);

    // Invalid config, then a valid one clears Error
    set_cfg(8'd3, 16'd3, 32'h0000_000D);
    drv(0, 0, 1, 0);
    repeat (3) drv(0, 0, 0, 0);
    set_cfg(8'd0, 16'd5, 32'h0);
    drv(0, 0, 1, 0);
    set_cfg(8'd17, 16'd40, 32'h0);
    drv(0, 0, 1, 0);
    set_cfg(8'd1, 16'd2, 32'h0000_0003);
    drv(0, 0, 1, 0);
    drv(1, 32'hA0, 0, 0);
    drv(1, 32'hA1, 0, 0);
    repeat (5) drv(0, 0, 0, 0);

    // Abort after four of six words
    for (int i = 0; i < 6; i++) drv(1, 32'h30 + i, 0, 0);
    set_cfg(8'd3, 16'd6, 32'h0000_002D);
    base = n_strobes;
    drv(0, 0, 1, 0);
    guard = 0;
    while (n_strobes - base < 4 && guard < 50) begin
      drv(0, 0, 0, 0);
      guard++;
    end
    chk("abort_reached_4", n_strobes - base, 4);
    drv(0, 0, 0, 1);
    repeat (6) drv(0, 0, 0, 0);

    // Asynchronous reset in the middle of priming
    set_cfg(8'd16, 16'd20, 32'h9E37_79B9);
    drv(0, 0, 1, 0);
    drv(1, 32'h40, 0, 0);
    drv(0, 0, 0, 0);
    drv(1, 32'h41, 0, 0);
    drv(0, 0, 0, 0);
    #3;
    Rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_clear();
    @(posedge Clk);
    #3;
    Rst_n = 1'b1;
    #1;
    chk("midrst_push_ready", Push_Ready, 1'b1);
    repeat (3) drv(0, 0, 0, 0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      bit ab, st, pv;
      int kk;
      ab = ($urandom_range(0, 199) == 0);
      st = ($urandom_range(0, 9) == 0);
      pv = !ab && ($urandom_range(0, 99) < 55);
      kk = $urandom_range(1, MAXK);
      case ($urandom_range(0, 9))
        0: set_cfg(8'd0, 16'($urandom_range(1, 20)), $urandom);
        1: set_cfg(8'($urandom_range(MAXK + 1, 255)), 16'd300, $urandom);
        2: set_cfg(8'(kk), 16'($urandom_range(0, kk)), $urandom);
        default: set_cfg(8'(kk), 16'(kk + $urandom_range(1, 12)), $urandom);
      endcase
      drv(pv, $urandom, st, ab);
    end
    repeat (40) drv(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
